// File: rtl/correlacion_sequencer.sv
// -----------------------------------------------------------------------------
// correlacion_sequencer
//
// Control FSM for the correlation datapath
// (XNOR -> low-pass -> shift register -> moving average -> comparator).
//
// The block counts oversampled bit strobes into windows of SAMPLES*OSF bits.
// For each complete window it does the following:
//   - pulses the datapath strobe (P),
//   - holds Enable for a settle period,
//   - samples the comparator decision.
// Decisions are suppressed until the moving-average history holds N windows.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | not acquiring; waits for start
// CLEAR  | one cycle; datapath reset, counters and flags cleared
// FILL   | collecting strobes until a window completes
// STROBE | one cycle; P and Enable high
// SETTLE | Enable held for SETTLE cycles while the datapath settles
// DECIDE | one cycle; comparator sampled, window counted
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          synchronous, active-high reset
//   start_i          level; starts acquisition when sampled in IDLE
//   stop_i           level; aborts acquisition from any active state
//   sample_strobe_i  one new oversampled bit is present in the datapath
//   corr_in_i        comparator decision from the datapath
//   p_o              datapath strobe (filter / shift-register enable)
//   enable_corr_o    datapath enable (filter + comparator)
//   reset_corr_o     datapath reset (also forced high by reset_i)
//   busy_o           high in every state except IDLE
//   detect_o         last valid decision, held
//   detect_valid_o   one-cycle pulse when detect_o updates
//   overrun_o        sticky; a window completed outside FILL and was dropped
//   window_count_o   windows processed since start, saturating
// -----------------------------------------------------------------------------
module correlacion_sequencer #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    parameter int N       = 4,
    parameter int SETTLE  = 2,
    parameter int WCW     = 16
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           stop_i,
    input  logic           sample_strobe_i,
    input  logic           corr_in_i,
    output logic           p_o,
    output logic           enable_corr_o,
    output logic           reset_corr_o,
    output logic           busy_o,
    output logic           detect_o,
    output logic           detect_valid_o,
    output logic           overrun_o,
    output logic [WCW-1:0] window_count_o
);

    localparam int W   = SAMPLES * OSF;
    localparam int FCW = (W > 1) ? $clog2(W) : 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int NCW = (N > 0) ? $clog2(N + 1) : 1;

    localparam logic [FCW-1:0] FILL_LAST   = FCW'(W - 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE - 1);
    localparam logic [NCW-1:0] WARM_FULL   = NCW'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_STROBE,
        S_SETTLE,
        S_DECIDE
    } state_t;

    state_t         state_q, state_d;
    logic [FCW-1:0] fill_q;
    logic [SCW-1:0] settle_q;
    logic [NCW-1:0] warm_q;
    logic [WCW-1:0] wcount_q;
    logic           p_q;
    logic           en_q;
    logic           rc_q;
    logic           busy_q;
    logic           detect_q;
    logic           dvalid_q;
    logic           overrun_q;

    logic           active;
    logic           counting;
    logic           window_done;
    logic           abort;

    always_comb begin
        active      = (state_q != S_IDLE);
        counting    = (state_q == S_FILL)   || (state_q == S_STROBE) ||
                      (state_q == S_SETTLE) || (state_q == S_DECIDE);
        window_done = counting && sample_strobe_i && (fill_q == FILL_LAST);
        abort       = active && stop_i;

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i && !stop_i) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_FILL;
            S_FILL:   if (window_done) state_d = S_STROBE;
            S_STROBE: state_d = S_SETTLE;
            S_SETTLE: if (settle_q == '0) state_d = S_DECIDE;
            S_DECIDE: state_d = S_FILL;
            default:  state_d = S_IDLE;
        endcase
        // Stop wins over every other transition out of an active state.
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            fill_q    <= '0;
            settle_q  <= '0;
            warm_q    <= '0;
            wcount_q  <= '0;
            p_q       <= 1'b0;
            en_q      <= 1'b0;
            rc_q      <= 1'b0;
            busy_q    <= 1'b0;
            detect_q  <= 1'b0;
            dvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;

            // Outputs are registered off the next state, so they always
            // line up with the state register.
            p_q    <= (state_d == S_STROBE);
            en_q   <= (state_d == S_STROBE) || (state_d == S_SETTLE) ||
                      (state_d == S_DECIDE);
            rc_q   <= (state_d == S_CLEAR);
            busy_q <= (state_d != S_IDLE);

            dvalid_q <= 1'b0;

            if (abort) begin
                // Detect, window count and overrun hold. The fill count
                // is rebuilt by CLEAR on the next start.
            end else if (state_q == S_CLEAR) begin
                fill_q    <= '0;
                warm_q    <= '0;
                wcount_q  <= '0;
                overrun_q <= 1'b0;
            end else if (counting) begin
                if (sample_strobe_i) begin
                    if (fill_q == FILL_LAST) fill_q <= '0;
                    else                     fill_q <= fill_q + FCW'(1);
                end

                // A window that completes while the previous one is still
                // being processed is dropped; only the flag records it.
                if (window_done && (state_q != S_FILL)) overrun_q <= 1'b1;

                if (state_q == S_STROBE) begin
                    settle_q <= SETTLE_LOAD;
                end else if ((state_q == S_SETTLE) && (settle_q != '0)) begin
                    settle_q <= settle_q - SCW'(1);
                end

                if (state_q == S_DECIDE) begin
                    if (!(&wcount_q)) wcount_q <= wcount_q + WCW'(1);
                    if (warm_q < WARM_FULL) begin
                        warm_q <= warm_q + NCW'(1);
                    end else begin
                        detect_q <= corr_in_i;
                        dvalid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign p_o            = p_q;
    assign enable_corr_o  = en_q;
    assign reset_corr_o   = reset_i | rc_q;
    assign busy_o         = busy_q;
    assign detect_o       = detect_q;
    assign detect_valid_o = dvalid_q;
    assign overrun_o      = overrun_q;
    assign window_count_o = wcount_q;

endmodule
